// File: rtl/bpred_pkg.sv
// Shared types and sizing for the perceptron predictor training path.
// Row layout: weight 0 (bias) in the LSBs, weight i at slice [i].
package bpred_pkg;
  localparam int NUM_ROWS   = 64;
  localparam int HIST_LEN   = 8;
  localparam int WEIGHT_W   = 8;
  localparam int YW         = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 4;

  localparam int IDXW  = $clog2(NUM_ROWS);
  localparam int ROW_W = (HIST_LEN + 1) * WEIGHT_W;

  // floor(1.93*h + 14) in integer arithmetic
  function automatic int calc_theta(input int h);
    return (193 * h) / 100 + 14;
  endfunction

  localparam int THETA = calc_theta(HIST_LEN);

  typedef logic signed [WEIGHT_W-1:0]       weight_t;
  typedef logic [HIST_LEN:0][WEIGHT_W-1:0]  row_t;

  typedef enum logic [1:0] {IDLE, RD, MOD, WR} fsm_e;

  typedef struct packed {
    logic [IDXW-1:0]     idx;
    logic [HIST_LEN-1:0] hist;
    logic                dir;
  } train_req_t;
endpackage

// File: rtl/bpred_train_alu.sv
// Combinational perceptron update: each weight moves one step toward
// agreement with the resolved direction, saturating at the signed limits.
module perceptron_train_alu
  import bpred_pkg::*;
(
  input  row_t                row,
  input  logic [HIST_LEN-1:0] hist,
  input  logic                dir,
  output row_t                new_row
);
  localparam weight_t WMAX = weight_t'({1'b0, {(WEIGHT_W-1){1'b1}}});
  localparam weight_t WMIN = weight_t'({1'b1, {(WEIGHT_W-1){1'b0}}});

  for (genvar k = 0; k <= HIST_LEN; k++) begin : g_w
    logic    inc;
    weight_t w;
    if (k == 0) begin : g_bias
      assign inc = dir;
    end else begin : g_hist
      assign inc = (dir == hist[k-1]);
    end
    assign w = weight_t'(row[k]);
    assign new_row[k] = inc ? ((w == WMAX) ? w : w + weight_t'(1))
                            : ((w == WMIN) ? w : w - weight_t'(1));
  end
endmodule

// File: rtl/bpred_train_sched.sv
// Training scheduler: filters resolved branches, queues them, and performs
// read-modify-write on the shared weight RAM port, yielding to fetch.
module bpred_train_sched
  import bpred_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                execute_bpredictor_update,
  input  logic [IDXW-1:0]     execute_bpredictor_idx,
  input  logic [HIST_LEN-1:0] execute_bpredictor_hist,
  input  logic                execute_bpredictor_dir,
  input  logic                execute_bpredictor_miss,
  input  logic [YW-1:0]       execute_bpredictor_ymag,
  output logic                sched_execute_full,
  input  logic                fetch_sched_req,
  input  logic [IDXW-1:0]     fetch_sched_idx,
  output logic                sched_fetch_grant,
  output logic                sched_fetch_stall,
  output logic [IDXW-1:0]     tbl_addr,
  output logic                tbl_rd_en,
  input  logic [ROW_W-1:0]    tbl_rdata,
  output logic                tbl_wr_en,
  output logic [ROW_W-1:0]    tbl_wdata,
  output logic                sched_busy,
  output logic [7:0]          sched_drop_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  train_req_t      fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  fsm_e            state_q, state_d;
  train_req_t      work_q, in_req;
  row_t            new_row_q, alu_row;
  logic [SW-1:0]   starve_q;
  logic [7:0]      drop_q;

  logic qualify, full, push, drop, pop;
  logic train_active, starved, train_win;

  assign in_req  = '{idx: execute_bpredictor_idx, hist: execute_bpredictor_hist,
                     dir: execute_bpredictor_dir};
  assign qualify = execute_bpredictor_update &&
                   (execute_bpredictor_miss || execute_bpredictor_ymag <= YW'(THETA));
  assign full    = (count_q == CW'(FIFO_DEPTH));
  // Full is judged on the registered count, so a same-cycle pop never rescues a request.
  assign push    = qualify && !full;
  assign drop    = qualify && full;
  assign pop     = (state_q == IDLE) && (count_q != '0);

  assign train_active = (state_q == RD) || (state_q == WR);
  assign starved      = (starve_q >= SW'(STARVE_MAX));
  assign sched_fetch_grant = reset && fetch_sched_req && !(starved && train_active);
  assign sched_fetch_stall = reset && fetch_sched_req && starved && train_active;
  assign train_win    = train_active && !sched_fetch_grant;

  assign tbl_addr   = sched_fetch_grant ? fetch_sched_idx : work_q.idx;
  assign tbl_rd_en  = (state_q == RD) && train_win;
  assign tbl_wr_en  = (state_q == WR) && train_win;
  assign tbl_wdata  = new_row_q;
  assign sched_execute_full = full;
  assign sched_busy         = (state_q != IDLE) || (count_q != '0);
  assign sched_drop_cnt     = drop_q;

  perceptron_train_alu u_alu (
    .row     (row_t'(tbl_rdata)),
    .hist    (work_q.hist),
    .dir     (work_q.dir),
    .new_row (alu_row)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = RD;
      RD:      if (train_win)     state_d = MOD;
      MOD:                        state_d = WR;
      WR:      if (train_win)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[tail_q] <= in_req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      work_q    <= '0;
      new_row_q <= '0;
      starve_q  <= '0;
      drop_q    <= '0;
    end else begin
      state_q <= state_d;
      if (push) tail_q <= (tail_q == PW'(FIFO_DEPTH-1)) ? '0 : tail_q + PW'(1);
      if (pop) begin
        head_q <= (head_q == PW'(FIFO_DEPTH-1)) ? '0 : head_q + PW'(1);
        work_q <= fifo_q[head_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (state_q == MOD) new_row_q <= alu_row;
      if (train_win)                                 starve_q <= '0;
      else if (train_active && !starved)             starve_q <= starve_q + SW'(1);
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_bpred_train_sched.sv
// Directed bench: stimulus pushes expected RAM writes into a scoreboard
// that an independent monitor drains on every tbl_wr_en.
module tb_bpred_train_sched;
  import bpred_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                upd, u_dir, u_miss;
  logic [IDXW-1:0]     u_idx;
  logic [HIST_LEN-1:0] u_hist;
  logic [YW-1:0]       u_ymag;
  logic                full, grant, stall, rd_en, wr_en, busy;
  logic                f_req;
  logic [IDXW-1:0]     f_idx, addr;
  logic [ROW_W-1:0]    rdata, wdata;
  logic [7:0]          drop_cnt;

  bpred_train_sched dut (
    .clk(clk), .reset(reset),
    .execute_bpredictor_update(upd), .execute_bpredictor_idx(u_idx),
    .execute_bpredictor_hist(u_hist), .execute_bpredictor_dir(u_dir),
    .execute_bpredictor_miss(u_miss), .execute_bpredictor_ymag(u_ymag),
    .sched_execute_full(full), .fetch_sched_req(f_req), .fetch_sched_idx(f_idx),
    .sched_fetch_grant(grant), .sched_fetch_stall(stall), .tbl_addr(addr),
    .tbl_rd_en(rd_en), .tbl_rdata(rdata), .tbl_wr_en(wr_en), .tbl_wdata(wdata),
    .sched_busy(busy), .sched_drop_cnt(drop_cnt)
  );

  // Weight RAM model with registered read and a preload side port
  logic [ROW_W-1:0] ram [NUM_ROWS];
  logic             ram_clr, pl_en;
  logic [IDXW-1:0]  pl_addr;
  logic [ROW_W-1:0] pl_data;
  always @(posedge clk) begin
    if (ram_clr) for (int i = 0; i < NUM_ROWS; i++) ram[i] <= '0;
    else if (pl_en) ram[pl_addr] <= pl_data;
    else if (wr_en) ram[addr] <= wdata;
    if (rd_en) rdata <= ram[addr];
  end

  typedef struct { logic [IDXW-1:0] idx; logic [ROW_W-1:0] row; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  function automatic void chk(input string name, input logic [ROW_W-1:0] act,
                              input logic [ROW_W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (reset && wr_en) begin
      if (sb.size() == 0) chk("unexpected_write", ROW_W'(wr_en), '0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", ROW_W'(addr), ROW_W'(e.idx));
        chk("wr_data", wdata, e.row);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [IDXW-1:0] i, input logic [HIST_LEN-1:0] h,
                       input logic d, input logic m, input logic [YW-1:0] y);
    upd = 1'b1; u_idx = i; u_hist = h; u_dir = d; u_miss = m; u_ymag = y;
  endtask

  task automatic expect_wr(input logic [IDXW-1:0] i, input logic [ROW_W-1:0] r);
    exp_t e;
    e.idx = i; e.row = r;
    sb.push_back(e);
  endtask

  task automatic preload(input logic [IDXW-1:0] i, input logic [ROW_W-1:0] r);
    pl_en = 1'b1; pl_addr = i; pl_data = r;
    step();
    pl_en = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((busy || sb.size() != 0) && n < lim) begin step(); n++; end
    chk("wait_idle", ROW_W'(busy || (sb.size() != 0)), '0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic seen;
    logic ev;
    reset = 1'b0; upd = 1'b0; u_idx = '0; u_hist = '0; u_dir = 1'b0; u_miss = 1'b0;
    u_ymag = '0; f_req = 1'b0; f_idx = '0; ram_clr = 1'b1; pl_en = 1'b0;
    pl_addr = '0; pl_data = '0;
    step(); step();
    ram_clr = 1'b0;
    f_req = 1'b1; f_idx = 6'd3; #1;
    chk("reset_outputs", ROW_W'({grant, stall, rd_en, wr_en, busy, full, drop_cnt}), '0);
    f_req = 1'b0;
    step(); reset = 1'b1; step();

    // 1: basic update, latency rd@2 wr@4
    issue(6'd5, 8'hA5, 1'b1, 1'b1, 12'd100);
    expect_wr(6'd5, 72'h01FF01FFFF01FF0101);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) upd = 1'b0;
      @(negedge clk);
      if (c == 2) chk("t1_rd_cycle2", ROW_W'({rd_en, addr}), ROW_W'({1'b1, 6'd5}));
      if (c == 3) chk("t1_mod_no_port", ROW_W'({rd_en, wr_en}), '0);
      if (c == 4) chk("t1_wr_cycle4", ROW_W'(wr_en), ROW_W'(1'b1));
    end
    wait_idle(20);

    // 2: threshold filter
    issue(6'd10, 8'h33, 1'b1, 1'b0, 12'd30);
    step(); upd = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (busy || rd_en || wr_en) seen = 1'b1; end
    chk("t2_filtered_quiet", ROW_W'(seen), '0);
    issue(6'd6, 8'h00, 1'b0, 1'b0, 12'd29);
    expect_wr(6'd6, 72'h0101010101010101FF);
    step(); upd = 1'b0;
    wait_idle(20);

    // 3: saturation at both limits
    preload(6'd7, {9{8'h7F}});
    issue(6'd7, 8'hFF, 1'b1, 1'b1, 12'd0);
    expect_wr(6'd7, {9{8'h7F}});
    step(); upd = 1'b0;
    wait_idle(20);
    preload(6'd8, {9{8'h80}});
    issue(6'd8, 8'hFF, 1'b0, 1'b1, 12'd0);
    expect_wr(6'd8, {9{8'h80}});
    step(); upd = 1'b0;
    wait_idle(20);

    // 4: starvation under continuous fetch
    f_req = 1'b1; f_idx = 6'd1;
    issue(6'd9, 8'h0F, 1'b1, 1'b1, 12'd0);
    expect_wr(6'd9, 72'hFFFFFFFF0101010101);
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 1) upd = 1'b0;
      @(negedge clk);
      if (c >= 2 && c <= 12) begin
        ev = (c == 6) || (c == 12);
        chk($sformatf("t4_arb_c%0d", c), ROW_W'({grant, stall, rd_en, wr_en}),
            ROW_W'({!ev, ev, (c == 6), (c == 12)}));
      end
    end
    wait_idle(40);

    // 5: overflow while fetch hogs the port
    issue(6'd20, 8'hFF, 1'b1, 1'b1, 12'd0);
    for (int i = 20; i <= 24; i++) expect_wr(IDXW'(i), {9{8'h01}});
    for (int c = 1; c <= 7; c++) begin
      step();
      upd = (c >= 2 && c <= 6);
      u_idx = IDXW'(19 + c);
      @(negedge clk);
      if (c == 5) chk("t5_not_full_at_3", ROW_W'(full), '0);
      if (c == 6) chk("t5_full_after_4", ROW_W'(full), ROW_W'(1'b1));
      if (c == 7) chk("t5_drop_cnt", ROW_W'(drop_cnt), ROW_W'(8'd1));
    end
    step();
    wait_idle(400);
    chk("t5_dropped_row_untouched", ram[25], '0);

    // 6: reset during MOD abandons the RMW and clears the queue
    f_req = 1'b0;
    issue(6'd30, 8'h00, 1'b1, 1'b1, 12'd0);
    step(); u_idx = 6'd31;
    step(); upd = 1'b0;
    step();
    reset = 1'b0; #1;
    chk("t6_reset_outputs", ROW_W'({grant, stall, rd_en, wr_en, busy, full, drop_cnt}), '0);
    step(); step();
    reset = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (wr_en || rd_en) seen = 1'b1; end
    chk("t6_no_tbl_after_reset", ROW_W'(seen), '0);
    chk("t6_fifo_empty", ROW_W'(busy), '0);
    chk("t6_row30_untouched", ram[30], '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
